// File: rtl/uart_tx_fifo_if.sv
// Receiver/transmitter-side signal bundle for uart_tx_fifo.
// slave = the FIFO block, master = whatever drives rx and busy (receiver/transmitter or bench).
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_en;
  logic [AW:0]       fifo_count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [15:0]       drop_cnt;

  modport master (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_en, fifo_count, full, empty, overflow, drop_cnt
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_en, fifo_count, full, empty, overflow, drop_cnt
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between UART RX and TX; launches one byte per transmitter busy cycle.
// Optional saturating dropped-byte counter: define UART_TX_FIFO_DROP_CNT_EN.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          sys_clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              full, empty, pop, push;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = WAIT_BUSY;
          timer_d = '0;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never raises busy still gets the byte counted as sent.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push       = bus.rx_valid && (!full || pop);
    overflow_d = bus.rx_valid && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    tx_data_d  = pop  ? mem_q[rd_ptr_q] : tx_data_q;
    tx_en_d    = pop;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      timer_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.fifo_count = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus directed
// latency/spacing/full/reset/saturation scenarios and a randomized traffic phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  uart_tx_fifo_if #(.DATA_W(8), .AW(4)) bus ();

  uart_tx_fifo #(
    .DATA_W      (8),
    .DEPTH       (DEPTH),
    .AW          (4),
    .BUSY_TIMEOUT(4)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] q[$];
  logic [7:0] emitted[$];
  int         en_times[$];
  logic [7:0] exp_tx   = '0;
  int         drops    = 0;
  logic       prev_en  = 1'b0;
  // 0: busy low, 1: busy held high, 2: busy for a few cycles after each launch
  int         busy_mode = 0;
  int         busy_left = 0;
  int         busy_min  = 1;
  int         busy_max  = 4;
  int         start     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic        full_before;
    logic        popped;
    logic        exp_ovf;
    logic [31:0] exp_drop;
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    exp_ovf = 1'b0;
    popped  = 1'b0;
    if (r) begin
      q.delete();
      exp_tx = '0;
      drops  = 0;
      check("rst_tx_en", 32'(bus.tx_en), 32'd0);
    end else begin
      full_before = (q.size() == DEPTH);
      popped      = (bus.tx_en === 1'b1);
      if (popped) begin
        check("pop_nonempty", 32'(q.size() > 0), 32'd1);
        check("en_single", 32'(prev_en), 32'd0);
        if (q.size() > 0) exp_tx = q.pop_front();
        emitted.push_back(bus.tx_data);
        en_times.push_back(cyc);
      end
      if (v) begin
        if (!full_before || popped) q.push_back(d);
        else begin
          exp_ovf = 1'b1;
          if (drops < 65535) drops++;
        end
      end
    end
`ifdef UART_TX_FIFO_DROP_CNT_EN
    exp_drop = 32'(drops);
`else
    exp_drop = 32'd0;
`endif
    check("tx_data", 32'(bus.tx_data), 32'(exp_tx));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("drop_cnt", 32'(bus.drop_cnt), exp_drop);
    prev_en = popped;
    case (busy_mode)
      0: bus.tx_busy = 1'b0;
      1: bus.tx_busy = 1'b1;
      default: begin
        if (popped) begin
          busy_left   = int'($urandom_range(busy_max, busy_min));
          bus.tx_busy = 1'b1;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.tx_busy = 1'b0;
        end
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() > 0; i++) cycle(1'b0, 1'b0, 8'h00);
    idle(30);
    check("drain_empty", 32'(bus.empty), 32'd1);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_busy  = 1'b0;
    @(negedge sys_clk);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("reset_count", 32'(bus.fifo_count), 32'd0);
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_full", 32'(bus.full), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    check("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);

    // Single byte, idle transmitter: launch two edges after capture
    busy_mode = 0;
    idle(1);
    en_times.delete();
    emitted.delete();
    start = cyc;
    cycle(1'b0, 1'b1, 8'hA5);
    check("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
    check("t1_not_empty", 32'(bus.empty), 32'd0);
    check("t1_no_fallthrough", 32'(bus.tx_en), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    check("t1_tx_en", 32'(bus.tx_en), 32'd1);
    check("t1_tx_data", 32'(bus.tx_data), 32'hA5);
    cycle(1'b0, 1'b0, 8'h00);
    check("t1_tx_en_pulse", 32'(bus.tx_en), 32'd0);
    check("t1_count_zero", 32'(bus.fifo_count), 32'd0);
    check("t1_empty", 32'(bus.empty), 32'd1);
    idle(8);
    check("t1_launches", 32'(en_times.size()), 32'd1);
    check("t1_latency", 32'(en_times.size() > 0 ? en_times[0] - start : -1), 32'd2);

    // Busy never rises: launches spaced by the timeout path
    en_times.delete();
    emitted.delete();
    cycle(1'b0, 1'b1, 8'h31);
    cycle(1'b0, 1'b1, 8'h32);
    cycle(1'b0, 1'b1, 8'h33);
    idle(20);
    check("t2_launches", 32'(en_times.size()), 32'd3);
    for (int i = 1; i < en_times.size(); i++)
      check("t2_spacing", 32'(en_times[i] - en_times[i-1]), 32'd5);
    for (int i = 0; i < emitted.size() && i < 3; i++)
      check("t2_order", 32'(emitted[i]), 32'(8'h31 + i));

    // Fill with busy held, then overflow
    busy_mode   = 1;
    bus.tx_busy = 1'b1;
    en_times.delete();
    emitted.delete();
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 8'(i));
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_count16", 32'(bus.fifo_count), 32'd16);
    check("t3_no_launch", 32'(en_times.size()), 32'd0);
    cycle(1'b0, 1'b1, 8'h11);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd1);
`else
    check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
    cycle(1'b0, 1'b0, 8'h00);
    check("t3_overflow_pulse", 32'(bus.overflow), 32'd0);

    // Pop and push on the same edge while full
    busy_mode   = 2;
    busy_min    = 1;
    busy_max    = 6;
    bus.tx_busy = 1'b0;
    cycle(1'b0, 1'b1, 8'h55);
    check("t4_pop", 32'(bus.tx_en), 32'd1);
    check("t4_count16", 32'(bus.fifo_count), 32'd16);
    check("t4_no_overflow", 32'(bus.overflow), 32'd0);
    drain();
    check("t4_emitted", 32'(emitted.size()), 32'd17);
    for (int i = 0; i < emitted.size() && i < 17; i++)
      check("t4_order", 32'(emitted[i]), (i < 16) ? 32'(i + 1) : 32'h55);

    // Randomized traffic, light then heavy load
    busy_max = 8;
    for (int i = 0; i < 3000; i++)
      cycle(1'b0, ($urandom_range(99) < ((i < 1500) ? 40 : 85)), 8'($urandom));
    drain();

    // Reset with five bytes queued while the transmitter is busy
    busy_min = 20;
    busy_max = 20;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'hE0 + i));
    check("t6_queued", 32'(bus.fifo_count), 32'd5);
    check("t6_busy", 32'(bus.tx_busy), 32'd1);
    cycle(1'b1, 1'b0, 8'h00);
    check("t6_count", 32'(bus.fifo_count), 32'd0);
    check("t6_tx_en", 32'(bus.tx_en), 32'd0);
    check("t6_tx_data", 32'(bus.tx_data), 32'd0);
    check("t6_empty", 32'(bus.empty), 32'd1);
    busy_mode   = 0;
    busy_left   = 0;
    bus.tx_busy = 1'b0;
    en_times.delete();
    idle(20);
    check("t6_no_launch", 32'(en_times.size()), 32'd0);
    cycle(1'b0, 1'b1, 8'hC3);
    cycle(1'b0, 1'b0, 8'h00);
    check("t6_idle_launch", 32'(bus.tx_en), 32'd1);
    check("t6_idle_data", 32'(bus.tx_data), 32'hC3);
    idle(10);

    // Drop counter saturation
    busy_mode   = 1;
    bus.tx_busy = 1'b1;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, 8'($urandom));
    check("t7_drop_sat", 32'(bus.drop_cnt), 32'hFFFF);
`else
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'($urandom));
    check("t7_drop_tied", 32'(bus.drop_cnt), 32'd0);
`endif
    check("t7_overflow", 32'(bus.overflow), 32'd1);
    cycle(1'b1, 1'b0, 8'h00);
    check("t7_drop_clear", 32'(bus.drop_cnt), 32'd0);
    check("t7_count_clear", 32'(bus.fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and TX launcher between the UART receiver and transmitter in the loopback path. Captures every byte the receiver flags valid, queues it in a small FIFO, and feeds the transmitter one byte at a time, pacing on the transmitter's busy flag. Prevents bytes being lost when the host sends back-to-back frames while the transmitter is still shifting.

Parameters:
DATA_W, 8, byte width.
DEPTH, 16, FIFO entries; power of two, at least 2.
AW, 4, address width; equals log2(DEPTH).
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a launch, at least 2.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
rx_data  input  DATA_W  byte from the receiver; valid only while rx_valid=1.
rx_valid  input  1  one-cycle strobe from the receiver.
tx_busy  input  1  transmitter busy flag.
tx_data  output  DATA_W  byte presented to the transmitter; registered.
tx_en  output  1  one-cycle launch strobe to the transmitter; registered.
fifo_count  output  AW+1  occupancy, 0 to DEPTH.
full  output  1  fifo_count==DEPTH.
empty  output  1  fifo_count==0.
overflow  output  1  one-cycle pulse when an incoming byte is dropped.
drop_cnt  output  16  dropped-byte counter; see Optional Feature.

Behaviour:
- Reset, sampled synchronously: wr_ptr=0, rd_ptr=0, fifo_count=0, empty=1, full=0, tx_data=0, tx_en=0, overflow=0, drop_cnt=0, FSM=IDLE, timer=0.
- Reset mid-frame discards all queued bytes and aborts any wait; the transmitter is not signalled.
- Write: on an edge with rx_valid=1, the byte goes to mem[wr_ptr] and wr_ptr increments, wrapping at DEPTH.
  - If full=1 and no pop on that edge, the byte is dropped and overflow=1 for the next cycle.
  - If full=1 and a pop occurs on the same edge, the write is accepted and fifo_count stays at DEPTH.
- No fall-through: a byte written into an empty FIFO is eligible for pop on the following edge.
- Pop: mem[rd_ptr] is registered into tx_data, rd_ptr increments with wrap, and tx_en=1 for exactly one cycle.
- fifo_count changes by +1 (push only), -1 (pop only) or 0 (both or neither). full and empty are derived from the registered count.
- tx_data holds its value until the next pop.
- FSM, IDLE:
  - If empty=0 and tx_busy=0: pop and go to WAIT_BUSY with timer=0.
  - Otherwise stay in IDLE.
- FSM, WAIT_BUSY:
  - If tx_busy=1: go to WAIT_DONE.
  - Else increment timer. When timer reaches BUSY_TIMEOUT-1, return to IDLE; the byte counts as sent and no retry is made.
- FSM, WAIT_DONE: if tx_busy=0, go to IDLE; otherwise stay.
- Latency, empty FIFO and idle transmitter: rx_valid sampled at edge N gives empty=0 after N, pop at edge N+1, tx_en high in cycle N+1..N+2. Byte-to-launch is 2 edges.
- Minimum spacing between tx_en pulses is 3 cycles (IDLE, then WAIT_BUSY, then WAIT_DONE) plus the transmitter's busy time.
- FIFO order is strict; no byte is reordered or duplicated.

Optional Feature:
UART_TX_FIFO_DROP_CNT_EN
- Defined: drop_cnt increments by 1 on every dropped byte, saturates at 16'hFFFF, and clears only on rst.
- Undefined: drop_cnt is tied to 0 and the counter logic is not built. overflow is present either way.

Test Plan:
- Reset then idle, tx_busy=0, one rx_valid with rx_data=8'hA5 -> tx_en single pulse 2 edges later, tx_data=8'hA5, fifo_count returns to 0, empty=1.
- tx_busy held 1; push 8'h01..8'h10 (16 bytes) -> full=1, fifo_count=16, no tx_en. Push 8'h11 -> overflow pulse, drop_cnt=1 when the macro is defined (0 when not). Release tx_busy with a model asserting busy 1 cycle after tx_en for 100 cycles -> bytes 01..10 emitted in order, 8'h11 never emitted.
- Full FIFO, pop and rx_valid (8'h55) on the same edge -> write accepted, fifo_count stays 16, 8'h55 emitted last.
- Transmitter model never raises tx_busy; queue 3 bytes -> each tx_en pulse is BUSY_TIMEOUT+1=5 cycles after the previous one, all 3 emitted.
- rst asserted for 1 cycle with 5 bytes queued and FSM in WAIT_DONE -> next cycle fifo_count=0, tx_en=0, tx_data=0, FSM=IDLE, no further tx_en.
- Macro defined, tx_busy held 1, 70000 rx_valid strobes -> drop_cnt saturates at 16'hFFFF.
